// File: rtl/header_deparser_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : header_deparser_pipe_if
// Brief    : Field-set handshake and byte-stream bus of the header deparser.
// Revision : 1.0 - initial release
// ============================================================================
interface header_deparser_pipe_if;
    logic        fld_valid;
    logic        fld_ready;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        has_vlan;
    logic [11:0] vlan_id;
    logic        is_ipv4;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl;
    logic [7:0]  ip_proto;
    logic [15:0] ip_total_len;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (
        output fld_valid, dst_mac, src_mac, has_vlan, vlan_id, is_ipv4, dscp, ecn,
               ttl, ip_proto, ip_total_len, src_ip, dst_ip, src_port, dst_port, tx_ready,
        input  fld_ready, tx_data, tx_valid, tx_last
    );

    modport slave (
        input  fld_valid, dst_mac, src_mac, has_vlan, vlan_id, is_ipv4, dscp, ecn,
               ttl, ip_proto, ip_total_len, src_ip, dst_ip, src_port, dst_port, tx_ready,
        output fld_ready, tx_data, tx_valid, tx_last
    );
endinterface
`default_nettype wire

// File: rtl/header_deparser_pipe.sv
`default_nettype none
// ============================================================================
// Module   : header_deparser_pipe
// Brief    : Serialises latched Ethernet/VLAN/IPv4/L4 header fields into bytes.
// Revision : 1.0 - initial release
// ============================================================================
module header_deparser_pipe (
    input  wire logic          clk,
    input  wire logic          rst_n,
    header_deparser_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CSUM = 2'd1,
        S_FOLD = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    localparam logic [3:0]  LAST_WORD    = 4'd9;
    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ETYPE_OTHER  = 16'h88B5;

    state_t      state;
    logic [47:0] dst_q, src_q;
    logic        vlan_q, ipv4_q;
    logic [11:0] vid_q;
    logic [5:0]  dscp_q;
    logic [1:0]  ecn_q;
    logic [7:0]  ttl_q, proto_q;
    logic [15:0] len_q, sp_q, dp_q;
    logic [31:0] sip_q, dip_q;
    logic [19:0] acc;
    logic [3:0]  word_cnt;
    logic [15:0] csum;
    logic [5:0]  idx;
    logic [7:0]  data_q;
    logic        valid_q, last_q;

    logic        l4;
    logic [5:0]  frame_len, last_idx, byte_sel, vpos;
    logic [15:0] csum_word;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [95:0] mac_sh;
    logic [239:0] tail, tail_sh;
    logic [7:0]  nxt_byte;

    assign l4        = ipv4_q && (proto_q == 8'd6 || proto_q == 8'd17);
    assign frame_len = 6'd14 + (vlan_q ? 6'd4 : 6'd0) + (ipv4_q ? 6'd20 : 6'd0) + (l4 ? 6'd4 : 6'd0);
    assign last_idx  = frame_len - 6'd1;
    assign byte_sel  = idx + 6'd1;

    always_comb begin
        csum_word = 16'h0000;
        case (word_cnt)
            4'd0:    csum_word = {8'h45, dscp_q, ecn_q};
            4'd1:    csum_word = len_q;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {ttl_q, proto_q};
            4'd6:    csum_word = sip_q[31:16];
            4'd7:    csum_word = sip_q[15:0];
            4'd8:    csum_word = dip_q[31:16];
            4'd9:    csum_word = dip_q[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    assign fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

    // Bytes after the MACs are laid out as if a VLAN tag were always present;
    // untagged frames simply skip the first four virtual positions.
    assign tail = {16'h8100, 4'h0, vid_q,
                   ipv4_q ? ETYPE_IPV4 : ETYPE_OTHER,
                   8'h45, dscp_q, ecn_q, len_q, 16'h0000, 16'h4000, ttl_q, proto_q, csum,
                   sip_q, dip_q,
                   sp_q, dp_q};

    always_comb begin
        vpos     = byte_sel - 6'd12 + (vlan_q ? 6'd0 : 6'd4);
        mac_sh   = {dst_q, src_q} << {byte_sel, 3'b000};
        tail_sh  = tail << {vpos, 3'b000};
        nxt_byte = 8'h00;
        if (byte_sel < 6'd12) begin
            nxt_byte = mac_sh[95:88];
        end else if (vpos <= 6'd29) begin
            nxt_byte = tail_sh[239:232];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dst_q    <= '0;
            src_q    <= '0;
            vlan_q   <= 1'b0;
            vid_q    <= '0;
            ipv4_q   <= 1'b0;
            dscp_q   <= '0;
            ecn_q    <= '0;
            ttl_q    <= '0;
            proto_q  <= '0;
            len_q    <= '0;
            sip_q    <= '0;
            dip_q    <= '0;
            sp_q     <= '0;
            dp_q     <= '0;
            acc      <= '0;
            word_cnt <= '0;
            csum     <= '0;
            idx      <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.fld_valid) begin
                        dst_q    <= bus.dst_mac;
                        src_q    <= bus.src_mac;
                        vlan_q   <= bus.has_vlan;
                        vid_q    <= bus.vlan_id;
                        ipv4_q   <= bus.is_ipv4;
                        dscp_q   <= bus.dscp;
                        ecn_q    <= bus.ecn;
                        ttl_q    <= bus.ttl;
                        proto_q  <= bus.ip_proto;
                        len_q    <= bus.ip_total_len;
                        sip_q    <= bus.src_ip;
                        dip_q    <= bus.dst_ip;
                        sp_q     <= bus.src_port;
                        dp_q     <= bus.dst_port;
                        acc      <= '0;
                        word_cnt <= '0;
                        idx      <= '0;
                        if (bus.is_ipv4) begin
                            state <= S_CSUM;
                        end else begin
                            // No checksum needed: first byte comes straight from the inputs.
                            state   <= S_EMIT;
                            valid_q <= 1'b1;
                            data_q  <= bus.dst_mac[47:40];
                            last_q  <= 1'b0;
                        end
                    end
                end
                S_CSUM: begin
                    acc      <= acc + {4'd0, csum_word};
                    word_cnt <= word_cnt + 4'd1;
                    if (word_cnt == LAST_WORD) begin
                        state <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    csum    <= ~fold2;
                    state   <= S_EMIT;
                    valid_q <= 1'b1;
                    data_q  <= dst_q[47:40];
                    last_q  <= 1'b0;
                end
                S_EMIT: begin
                    if (bus.tx_ready) begin
                        idx <= byte_sel;
                        if (last_q) begin
                            state   <= S_IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            data_q <= nxt_byte;
                            last_q <= (byte_sel == last_idx);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.fld_ready = (state == S_IDLE);
    assign bus.tx_data   = data_q;
    assign bus.tx_valid  = valid_q;
    assign bus.tx_last   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_header_deparser_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_header_deparser_pipe
// Brief    : Randomised self-checking bench with a byte-queue frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_header_deparser_pipe;

    typedef struct {
        logic [47:0] dst, src;
        logic        vlan;
        logic [11:0] vid;
        logic        ipv4;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [7:0]  ttl, proto;
        logic [15:0] len;
        logic [31:0] sip, dip;
        logic [15:0] sp, dp;
    } fields_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    header_deparser_pipe_if bus();
    header_deparser_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap[64];
    logic [7:0] ref_cap[64];
    int  cap_n = 0, ref_n = 0;
    int  acc_cnt = 0;
    bit  lat_wait = 0;
    int  lat_cnt = 0, lat_exp = 0;
    bit  prev_rst_low = 0;
    bit  post_last = 0;
    int  cyc = 0, last_cyc = 0;
    bit  b2b_mode = 0;
    int  stall_pct = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame built byte by byte from the field rules.
    task automatic build(input fields_t f, output logic [7:0] q[$]);
        int s;
        logic [15:0] cs;
        logic [7:0] b[$];
        s = 'h4500 + {f.dscp, f.ecn} + f.len + 'h4000 + {f.ttl, f.proto}
            + f.sip[31:16] + f.sip[15:0] + f.dip[31:16] + f.dip[15:0];
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        for (int i = 5; i >= 0; i--) b.push_back(f.dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(f.src[8*i +: 8]);
        if (f.vlan) begin
            b.push_back(8'h81); b.push_back(8'h00);
            b.push_back({4'h0, f.vid[11:8]}); b.push_back(f.vid[7:0]);
        end
        if (f.ipv4) begin
            b.push_back(8'h08); b.push_back(8'h00);
            b.push_back(8'h45); b.push_back({f.dscp, f.ecn});
            b.push_back(f.len[15:8]); b.push_back(f.len[7:0]);
            b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
            b.push_back(f.ttl); b.push_back(f.proto);
            b.push_back(cs[15:8]); b.push_back(cs[7:0]);
            for (int i = 3; i >= 0; i--) b.push_back(f.sip[8*i +: 8]);
            for (int i = 3; i >= 0; i--) b.push_back(f.dip[8*i +: 8]);
            if (f.proto == 8'd6 || f.proto == 8'd17) begin
                b.push_back(f.sp[15:8]); b.push_back(f.sp[7:0]);
                b.push_back(f.dp[15:8]); b.push_back(f.dp[7:0]);
            end
        end else begin
            b.push_back(8'h88); b.push_back(8'hB5);
        end
        q = b;
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        int p;
        f.dst  = {$urandom(), $urandom()} >> 16;
        f.src  = {$urandom(), $urandom()} >> 16;
        f.vlan = 1'($urandom_range(0, 1));
        f.vid  = 12'($urandom());
        f.ipv4 = ($urandom_range(0, 3) != 0);
        f.dscp = 6'($urandom());
        f.ecn  = 2'($urandom());
        f.ttl  = 8'($urandom());
        p = $urandom_range(0, 3);
        f.proto = (p == 0) ? 8'd6 : (p == 1) ? 8'd17 : (p == 2) ? 8'd1 : 8'($urandom());
        f.len  = 16'($urandom());
        f.sip  = $urandom();
        f.dip  = $urandom();
        f.sp   = 16'($urandom());
        f.dp   = 16'($urandom());
        return f;
    endfunction

    task automatic apply(input fields_t f);
        bus.dst_mac = f.dst;   bus.src_mac = f.src;
        bus.has_vlan = f.vlan; bus.vlan_id = f.vid;
        bus.is_ipv4 = f.ipv4;  bus.dscp = f.dscp; bus.ecn = f.ecn;
        bus.ttl = f.ttl;       bus.ip_proto = f.proto; bus.ip_total_len = f.len;
        bus.src_ip = f.sip;    bus.dst_ip = f.dip;
        bus.src_port = f.sp;   bus.dst_port = f.dp;
    endtask

    function automatic fields_t sample_bus();
        fields_t f;
        f.dst = bus.dst_mac;   f.src = bus.src_mac;
        f.vlan = bus.has_vlan; f.vid = bus.vlan_id;
        f.ipv4 = bus.is_ipv4;  f.dscp = bus.dscp; f.ecn = bus.ecn;
        f.ttl = bus.ttl;       f.proto = bus.ip_proto; f.len = bus.ip_total_len;
        f.sip = bus.src_ip;    f.dip = bus.dst_ip;
        f.sp = bus.src_port;   f.dp = bus.dst_port;
        return f;
    endfunction

    // Compare process: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        logic [7:0] tmp[$];
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            lat_wait = 0;
            post_last = 0;
            prev_rst_low = 1;
        end else begin
            if (prev_rst_low) begin
                chk("rst_tx_valid", 64'(bus.tx_valid), 0);
                chk("rst_tx_last", 64'(bus.tx_last), 0);
                chk("rst_tx_data", 64'(bus.tx_data), 0);
                chk("rst_fld_ready", 64'(bus.fld_ready), 1);
                prev_rst_low = 0;
            end
            if (post_last) begin
                chk("bubble_tx_valid", 64'(bus.tx_valid), 0);
                chk("bubble_fld_ready", 64'(bus.fld_ready), 1);
                post_last = 0;
            end
            if (lat_wait) begin
                lat_cnt++;
                if (bus.tx_valid) begin
                    chk("first_byte_latency", 64'(lat_cnt), 64'(lat_exp));
                    lat_wait = 0;
                end else if (lat_cnt > 20) begin
                    chk("first_byte_timeout", 1, 0);
                    lat_wait = 0;
                    exp_q.delete();
                end
            end
            if (bus.tx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_valid", 1, 0);
                end else begin
                    chk("tx_data", 64'(bus.tx_data), 64'(exp_q[0]));
                    chk("tx_last", 64'(bus.tx_last), 64'(exp_q.size() == 1));
                    chk("fld_ready_busy", 64'(bus.fld_ready), 0);
                    if (bus.tx_ready) begin
                        if (cap_n < 64) cap[cap_n] = bus.tx_data;
                        cap_n++;
                        void'(exp_q.pop_front());
                        if (bus.tx_last) begin
                            post_last = 1;
                            last_cyc = cyc;
                        end
                    end
                end
            end
            if (bus.fld_valid && bus.fld_ready) begin
                build(sample_bus(), tmp);
                foreach (tmp[i]) exp_q.push_back(tmp[i]);
                if (b2b_mode) chk("b2b_gap_cycles", 64'(cyc - last_cyc), 1);
                acc_cnt++;
                cap_n = 0;
                lat_wait = 1;
                lat_cnt = 0;
                lat_exp = bus.is_ipv4 ? 12 : 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            bus.tx_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
        end
    end

    task automatic send(input fields_t f);
        int n = 0;
        while (!bus.fld_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("ready_wait", 64'(n < 100), 1);
        apply(f);
        bus.fld_valid = 1'b1;
        @(posedge clk); #1;
        bus.fld_valid = 1'b0;
        apply(rand_fields());
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || lat_wait || bus.tx_valid) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("frame_done", 64'(n < 400), 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        fields_t f, g;
        logic [7:0] mq[$];
        int n, a0, bad;
        bus.fld_valid = 1'b0;
        bus.tx_ready = 1'b1;
        apply(rand_fields());
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Plain Ethernet, broadcast destination.
        f = rand_fields();
        f.dst = 48'hFFFF_FFFF_FFFF; f.src = 48'h0011_2233_4455; f.vlan = 0; f.ipv4 = 0;
        send(f); wait_done();
        chk("eth_len", 64'(cap_n), 14);
        chk("eth_b0", 64'(cap[0]), 8'hFF);
        chk("eth_b11", 64'(cap[11]), 8'h55);
        chk("eth_b12", 64'(cap[12]), 8'h88);
        chk("eth_b13", 64'(cap[13]), 8'hB5);

        // IPv4/UDP with a known checksum.
        f = rand_fields();
        f.vlan = 0; f.ipv4 = 1; f.dscp = 0; f.ecn = 0; f.len = 16'h0073; f.ttl = 8'h40;
        f.proto = 8'h11; f.sip = 32'hC0A8_0001; f.dip = 32'hC0A8_00C7;
        build(f, mq);
        chk("model_csum_hi", 64'(mq[24]), 8'hB8);
        chk("model_csum_lo", 64'(mq[25]), 8'h61);
        send(f); wait_done();
        chk("udp_len", 64'(cap_n), 38);
        chk("udp_csum_hi", 64'(cap[24]), 8'hB8);
        chk("udp_csum_lo", 64'(cap[25]), 8'h61);
        chk("udp_etype_hi", 64'(cap[12]), 8'h08);

        // Tagged IPv4 ICMP: no L4 bytes.
        f = rand_fields();
        f.vlan = 1; f.vid = 12'hABC; f.ipv4 = 1; f.proto = 8'd1;
        send(f); wait_done();
        chk("vlan_len", 64'(cap_n), 38);
        chk("vlan_b12", 64'(cap[12]), 8'h81);
        chk("vlan_b13", 64'(cap[13]), 8'h00);
        chk("vlan_b14", 64'(cap[14]), 8'h0A);
        chk("vlan_b15", 64'(cap[15]), 8'hBC);

        // TCP frame without and with backpressure must match.
        f = rand_fields();
        f.vlan = 1; f.ipv4 = 1; f.proto = 8'd6;
        send(f); wait_done();
        ref_n = cap_n;
        for (int i = 0; i < 64; i++) ref_cap[i] = cap[i];
        chk("tcp_len", 64'(ref_n), 42);
        stall_pct = 50;
        send(f); wait_done();
        stall_pct = 0;
        bad = 0;
        for (int i = 0; i < 42; i++) if (cap[i] !== ref_cap[i]) bad++;
        chk("stall_len", 64'(cap_n), 64'(ref_n));
        chk("stall_bytes_differ", 64'(bad), 0);

        // Random frames under random backpressure.
        for (int k = 0; k < 25; k++) begin
            stall_pct = $urandom_range(0, 60);
            send(rand_fields());
            wait_done();
        end
        stall_pct = 0;

        // Reset during checksum, then at byte 20.
        f = rand_fields(); f.ipv4 = 1;
        send(f);
        repeat (3) begin @(posedge clk); #1; end
        pulse_reset();
        repeat (15) begin @(posedge clk); #1; end
        f = rand_fields(); f.ipv4 = 1; f.proto = 8'd17;
        send(f);
        n = 0;
        while (cap_n < 20 && n < 200) begin @(posedge clk); #1; n++; end
        chk("reach_byte20", 64'(n < 200), 1);
        pulse_reset();
        repeat (5) begin @(posedge clk); #1; end
        f = rand_fields(); f.vlan = 0; f.ipv4 = 1; f.proto = 8'd6;
        send(f); wait_done();
        chk("post_reset_len", 64'(cap_n), 38);

        // Back-to-back requests with fld_valid held high.
        f = rand_fields(); f.ipv4 = 0;
        g = rand_fields(); g.ipv4 = 0;
        a0 = acc_cnt;
        apply(f);
        bus.fld_valid = 1'b1;
        n = 0;
        while (acc_cnt == a0 && n < 100) begin @(posedge clk); #1; n++; end
        b2b_mode = 1;
        apply(g);
        a0 = acc_cnt;
        n = 0;
        while (acc_cnt == a0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("b2b_second_accept", 64'(n < 200), 1);
        bus.fld_valid = 1'b0;
        b2b_mode = 0;
        wait_done();
        chk("b2b_len", 64'(cap_n), g.vlan ? 18 : 14);

        repeat (3) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
